// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words onto the ccff configuration chain
// An optional verify pass compares the bits leaving ccff_tail with the bits entering ccff_head.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 66,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              mismatch
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int RW = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic              verify_q, verify_d;
   logic              mismatch_q, mismatch_d;
   logic [CW-1:0]     owed;
   logic              accept;

   assign ccff_shift_en = (state_q == S_LOAD) && (rem_q != '0);
   assign ccff_head     = ccff_shift_en & buf_q[0];
   assign owed          = CW'(CHAIN_LEN) - bit_cnt_q;

   // A new word may land on the same edge the buffer's last bit leaves, giving bubble-free streaming.
   assign word_ready = (state_q == S_LOAD)
                     && ((rem_q == '0) || ((rem_q == RW'(1)) && ccff_shift_en))
                     && (owed > CW'(rem_q));
   assign accept     = word_valid && word_ready;

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign mismatch = mismatch_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      buf_d      = buf_q;
      rem_d      = rem_q;
      verify_d   = verify_q;
      mismatch_d = mismatch_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               bit_cnt_d  = '0;
               buf_d      = '0;
               rem_d      = '0;
               verify_d   = verify;
               mismatch_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (ccff_shift_en) begin
               buf_d     = buf_q >> 1;
               rem_d     = rem_q - RW'(1);
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (verify_q && (ccff_tail != ccff_head)) begin
                  mismatch_d = 1'b1;
               end
               // Chain full: leftover bits of a partial final word are dropped.
               if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
                  state_d = S_DONE;
                  buf_d   = '0;
                  rem_d   = '0;
               end
            end
            if (accept) begin
               buf_d = word_in;
               rem_d = RW'(WORD_W);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         buf_q      <= '0;
         rem_q      <= '0;
         verify_q   <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         buf_q      <= buf_d;
         rem_q      <= rem_d;
         verify_q   <= verify_d;
         mismatch_q <= mismatch_d;
      end
   end

endmodule
